spi_byte_receiver: RTL and testbench
====================================

Name: spi_byte_receiver

Overview:
Memory-mapped SPI receive peripheral on the CPU data bus. It sits directly downstream of the SPI transmit controller and consumes that block's spi_clk_o, ss and mosi outputs. It oversamples the SPI lines in the CPU clock domain and reassembles MSB-first bytes into a FIFO. The CPU reads the FIFO and a status word through the same 32-bit tri-state bus protocol used by the other peripherals, which supports loopback test and board-to-board links.

Parameters:
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..64.
BASE_ADDR, 30'd1, word address of the DATA register; the STATUS register is at BASE_ADDR+1.

Ports:
clk  input  1  CPU clock; all logic is on its rising edge.
rst  input  1  asynchronous, active-high reset.
data_bus  inout  32  CPU data bus; driven only during a read of DATA or STATUS, high-Z otherwise.
data_address  input  30  CPU word address.
data_rw  input  1  1 = write, 0 = read.
data_cs  input  1  bus cycle valid.
sclk  input  1  SPI clock; idles 0; data is stable on the rising edge.
ss  input  1  SPI slave select, active low.
mosi  input  1  SPI serial data, MSB first.
irq  output  1  registered FIFO-not-empty flag.
overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Clocking and reset: one clock domain (clk) with an asynchronous, active-high reset (rst).
- Synchronisers: sclk, ss and mosi each pass through 2 flops. A third sclk flop provides rising-edge detection. Reset values of the sync flops are sclk=0, ss=1, mosi=0.
- Clock ratio: clk must be at least 4x sclk. Pin-to-detect latency is 3 clk.
- Receive FSM:
  - IDLE: wait for synced ss=0, then clear bit_cnt and shift_reg and enter SHIFT.
  - SHIFT, on each sclk rising edge: shift_reg <= {shift_reg[6:0], mosi_s}; bit_cnt++. On the 8th bit, push {shift_reg[6:0], mosi_s}, reset bit_cnt to 0 and stay in SHIFT, so back-to-back bytes need no ss toggle.
  - SHIFT, if synced ss=1: go to IDLE. If bit_cnt != 0, discard the partial byte and set the sticky frame_err flag.
  - Synced ss rising edge and sclk rising edge in the same cycle: ss wins and the bit is discarded.
- FIFO:
  - wr_ptr and rd_ptr are log2(FIFO_DEPTH)+1 bits wide, with an extra wrap bit.
  - count = wr_ptr - rd_ptr. empty when count == 0; full when count == FIFO_DEPTH. Pointers wrap naturally modulo 2*FIFO_DEPTH.
  - Push while full with no pop in the same cycle: the byte is dropped, contents are unchanged and overrun is set.
  - Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
  - Push and pop together when not full: both take effect and count is unchanged.
  - Pop when empty: ignored.
- Bus decode:
  - sel_data = data_cs & (data_address == BASE_ADDR).
  - sel_stat = data_cs & (data_address == BASE_ADDR+1).
- DATA read (data_rw=0, sel_data):
  - data_bus = {24'b0, fifo[rd_ptr]}, combinational from the FIFO head; reads 0 if empty.
  - The pop occurs in the cycle after the read select falls, i.e. previous-cycle read select = 1 and current = 0, so data stays stable for a multi-cycle access.
  - If the FIFO was empty at the start of the access, no pop occurs.
- STATUS read: data_bus = {19'b0, count[4:0] at bits [12:8], 4'b0, frame_err, overrun, full, !empty}. Bit order: [3] frame_err, [2] overrun, [1] full, [0] !empty.
- STATUS write (data_rw=1, sel_stat):
  - data_bus[2]=1 clears overrun; data_bus[3]=1 clears frame_err.
  - A set event in the same cycle as a clear wins, so the flag stays 1.
  - Clears act on every cycle the write is held.
- Writes to DATA: ignored.
- Outputs: irq <= !empty, registered with 1 clk lag. Byte visible to the CPU 1 clk after the push cycle.
- Reset values (async, any time including mid-byte): FSM=IDLE, bit_cnt=0, shift_reg=0, pointers=0, irq=0, overrun=0, frame_err=0, data_bus=Z. A partial byte is lost and no frame_err is raised. FIFO contents need not be cleared.

Test Plan:
- Single byte: ss low, send 0xA5 at clk/8, ss high -> irq=1; STATUS reads 0x00000101; DATA reads 0x000000A5; irq=0 one cycle after the pop.
- Burst: send 0x01, 0x80, 0xFF in one ss-low frame -> count=3; three DATA reads return 0x01, 0x80, 0xFF in order; STATUS reads 0x00000000 after the last pop.
- Overflow: send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> STATUS=0x00001007; reads return 0x00..0x0F; 0x10 is lost. Write 0x4 to STATUS -> overrun=0.
- Abort: ss high after 5 bits -> no push; frame_err=1 (STATUS bit3). A following full byte 0x3C is received correctly. Write 0x8 to STATUS -> frame_err cleared.
- Simultaneous push/pop and wrap: keep count at 1 while streaming 40 bytes, each popped as the next completes -> all 40 values are read in order; count never exceeds 2; pointers wrap with no loss.
- Reset mid-byte: assert rst after 4 bits with 2 bytes queued -> STATUS=0 and irq=0 immediately. Next full frame 0x5A reads back 0x5A.

Source files
------------

// File: rtl/spi_byte_receiver.sv
// Generic synchronous FIFO with wrap-bit pointers and an occupancy count.
// Latency: a pushed entry is visible at the head one clk after the push cycle.
// Backpressure: push while full is dropped (drop pulses) unless a pop frees the slot that cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_fire;
  logic             push_fire;

  // Pointers carry one extra wrap bit, so the difference is the true occupancy.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop_fire  = pop_vld & ~empty;
  assign push_fire = push_vld & (~full | pop_fire);
  assign drop      = push_vld & full & ~pop_fire;
  assign head_dat  = mem[rd_ptr[AW-1:0]];

  // Pointer update; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is left uninitialised; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// SPI slave receiver: oversamples sclk/ss/mosi, assembles MSB-first bytes into a FIFO read over the CPU bus.
// Latency: 3 clk pin-to-detect; byte readable 1 clk after its push; irq follows !empty by 1 clk.
// Backpressure: none toward SPI; bytes arriving while the FIFO is full are dropped and flag overrun.
module spi_byte_receiver #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [29:0] BASE_ADDR  = 30'd1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] data_bus,
  input  logic [29:0] data_address,
  input  logic        data_rw,
  input  logic        data_cs,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        irq,
  output logic        overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_nxt;

  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          ss_s1, ss_s2;
  logic          mosi_s1, mosi_s2;
  logic          sclk_rise;
  logic          ss_s;
  logic          mosi_s;

  logic          push_vld;
  logic [7:0]    push_dat;
  logic          frame_err_set;
  logic          frame_err;

  logic          pop_vld;
  logic [7:0]    head_dat;
  logic [CW-1:0] count;
  logic [6:0]    count_ext;
  logic          full;
  logic          empty;
  logic          drop;

  logic          sel_data;
  logic          sel_stat;
  logic          rd_sel;
  logic          rd_sel_q;
  logic          rd_armed;
  logic          bus_drive;
  logic [31:0]   rd_word;
  logic [31:0]   stat_word;
  logic          clr_ovr;
  logic          clr_fe;
  logic          bus_unused;

  // Two-flop synchronisers on all SPI pins, plus a third sclk stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign ss_s      = ss_s2;
  assign mosi_s    = mosi_s2;

  // Receive FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Receive FSM next state: ss deassertion takes priority over a coincident sclk edge.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_reg;
    push_vld      = 1'b0;
    push_dat      = {shift_reg[6:0], mosi_s};
    frame_err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ss_s) begin
          state_nxt   = ST_SHIFT;
          bit_cnt_nxt = 3'd0;
          shift_nxt   = 8'd0;
        end
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_nxt     = ST_IDLE;
          frame_err_set = (bit_cnt != 3'd0);
        end else if (sclk_rise) begin
          shift_nxt   = {shift_reg[6:0], mosi_s};
          bit_cnt_nxt = bit_cnt + 3'd1;
          push_vld    = (bit_cnt == 3'd7);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .drop     (drop)
  );

  assign sel_data = data_cs & (data_address == BASE_ADDR);
  assign sel_stat = data_cs & (data_address == BASE_ADDR + 30'd1);
  assign rd_sel   = sel_data & ~data_rw;
  assign clr_ovr  = sel_stat & data_rw & data_bus[2];
  assign clr_fe   = sel_stat & data_rw & data_bus[3];

  // Pop on the falling edge of a DATA read select, only if the access began with data present.
  assign pop_vld  = rd_sel_q & ~rd_sel & rd_armed;

  // Track the DATA read select and whether the access started on a non-empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_q <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      rd_sel_q <= rd_sel;
      if (rd_sel & ~rd_sel_q) rd_armed <= ~empty;
    end
  end

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)               overrun <= 1'b1;
      else if (clr_ovr)       overrun <= 1'b0;
      if (frame_err_set)      frame_err <= 1'b1;
      else if (clr_fe)        frame_err <= 1'b0;
    end
  end

  // Interrupt mirrors FIFO-not-empty with one clk of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= ~empty;
  end

  assign count_ext = 7'(count);
  assign stat_word = {19'd0, count_ext[4:0], 4'd0, frame_err, overrun, full, ~empty};
  assign rd_word   = sel_data ? {24'd0, (empty ? 8'h00 : head_dat)} : stat_word;
  assign bus_drive = ~data_rw & (sel_data | sel_stat);
  assign data_bus  = bus_drive ? rd_word : 32'bz;

  // Bus bits and count bits with no function in this block.
  assign bus_unused = ^{data_bus[31:4], data_bus[1:0], count_ext[6:5]};

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Self-checking bench for spi_byte_receiver: SPI frames at clk/8 against a queue-based model.
// Latency: checks irq lag, pop timing and byte visibility through bus reads.
// Backpressure: exercises FIFO overflow, aborts, and reads overlapping pushes.
module tb_spi_byte_receiver;

  localparam int          DEPTH = 16;
  localparam logic [29:0] BASE  = 30'd1;
  localparam logic [29:0] STAT  = 30'd2;

  logic        clk;
  logic        rst;
  wire  [31:0] data_bus;
  logic [29:0] data_address;
  logic        data_rw;
  logic        data_cs;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        irq;
  logic        overrun;

  logic        tb_drv;
  logic [31:0] tb_wdat;

  int          n_cmp;
  int          n_fail;

  // Reference model: queue contents plus the two sticky flags.
  logic [7:0]  mq[$];
  logic        m_ovr;
  logic        m_fe;

  assign data_bus = tb_drv ? tb_wdat : 32'bz;

  spi_byte_receiver #(
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_bus     (data_bus),
    .data_address (data_address),
    .data_rw      (data_rw),
    .data_cs      (data_cs),
    .sclk         (sclk),
    .ss           (ss),
    .mosi         (mosi),
    .irq          (irq),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    logic [4:0] c;
    c = 5'(mq.size());
    return {19'd0, c, 4'd0, m_fe, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  function automatic void model_push(input logic [7:0] v);
    if (mq.size() < DEPTH) mq.push_back(v);
    else m_ovr = 1'b1;
  endfunction

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Send the top n bits of v, MSB first.
  task automatic spi_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) spi_bit(v[i]);
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
    @(negedge clk);
    data_cs = 1'b1;
    data_rw = 1'b0;
    data_address = a;
    @(posedge clk);
    #1;
    d = data_bus;
    @(negedge clk);
    data_cs = 1'b0;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    data_cs = 1'b1;
    data_rw = 1'b1;
    data_address = a;
    tb_drv = 1'b1;
    tb_wdat = d;
    @(negedge clk);
    data_cs = 1'b0;
    data_rw = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL reset_status: got %08h want %08h", d, exp_status()); end
    bus_read(BASE, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %08h want 00000000", d); end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL empty_pop_status: got %08h want %08h", d, exp_status()); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic [31:0] e;
    ss_low();
    spi_bits(8'hA5, 8);
    model_push(8'hA5);
    ss_high();
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", irq); end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h00000101 || d !== exp_status()) begin n_fail++; $display("FAIL single_status: got %08h want 00000101", d); end
    bus_read(BASE, d);
    e = {24'd0, mq.pop_front()};
    n_cmp++;
    if (d !== e) begin n_fail++; $display("FAIL single_data: got %08h want %08h", d, e); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_lag: got %b want 1", irq); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_burst();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  vals [3];
    vals[0] = 8'h01;
    vals[1] = 8'h80;
    vals[2] = 8'hFF;
    ss_low();
    for (int i = 0; i < 3; i++) begin
      spi_bits(vals[i], 8);
      model_push(vals[i]);
    end
    ss_high();
    bus_write(BASE, 32'h000000EE);
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status() || d[12:8] !== 5'd3) begin n_fail++; $display("FAIL burst_status: got %08h want %08h", d, exp_status()); end
    for (int i = 0; i < 3; i++) begin
      bus_read(BASE, d);
      e = {24'd0, mq.pop_front()};
      n_cmp++;
      if (d !== e) begin n_fail++; $display("FAIL burst_data%0d: got %08h want %08h", i, d, e); end
    end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL burst_status_end: got %08h want 00000000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] e;
    ss_low();
    for (int i = 0; i <= 16; i++) begin
      spi_bits(8'(i), 8);
      model_push(8'(i));
    end
    ss_high();
    n_cmp++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovf_pin: got %b want 1", overrun); end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h00001007 || d !== exp_status()) begin n_fail++; $display("FAIL ovf_status: got %08h want 00001007", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(BASE, d);
      e = {24'd0, mq.pop_front()};
      n_cmp++;
      if (d !== e) begin n_fail++; $display("FAIL ovf_data%0d: got %08h want %08h", i, d, e); end
    end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL ovf_drained: got %08h want %08h", d, exp_status()); end
    bus_write(STAT, 32'h4);
    m_ovr = 1'b0;
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %08h/%b want 00000000/0", d, overrun); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic [31:0] e;
    ss_low();
    spi_bits(8'hFF, 5);
    ss_high();
    m_fe = 1'b1;
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h00000008 || d !== exp_status()) begin n_fail++; $display("FAIL abort_status: got %08h want 00000008", d); end
    ss_low();
    spi_bits(8'h3C, 8);
    model_push(8'h3C);
    ss_high();
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL abort_next_status: got %08h want %08h", d, exp_status()); end
    bus_read(BASE, d);
    e = {24'd0, mq.pop_front()};
    n_cmp++;
    if (d !== e) begin n_fail++; $display("FAIL abort_next_data: got %08h want %08h", d, e); end
    bus_write(STAT, 32'h8);
    m_fe = 1'b0;
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_clear: got %08h want 00000000", d); end
  endtask

  task automatic test_stream();
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] e;
    logic [7:0]  v;
    int          r;
    ss_low();
    v = 8'($urandom);
    spi_bits(v, 8);
    model_push(v);
    for (int k = 1; k < 40; k++) begin
      v = 8'($urandom);
      r = int'($urandom_range(0, 4));
      fork
        spi_bits(v, 8);
        begin
          repeat (2 + r) @(negedge clk);
          bus_read(BASE, d);
        end
      join
      e = {24'd0, mq.pop_front()};
      model_push(v);
      n_cmp++;
      if (d !== e) begin n_fail++; $display("FAIL stream_data%0d: got %08h want %08h", k - 1, d, e); end
      bus_read(STAT, s);
      n_cmp++;
      if (s !== exp_status() || s[12:8] > 5'd2) begin n_fail++; $display("FAIL stream_status%0d: got %08h want %08h", k, s, exp_status()); end
    end
    bus_read(BASE, d);
    e = {24'd0, mq.pop_front()};
    n_cmp++;
    if (d !== e) begin n_fail++; $display("FAIL stream_last: got %08h want %08h", d, e); end
    ss_high();
    bus_read(STAT, s);
    n_cmp++;
    if (s !== 32'h0) begin n_fail++; $display("FAIL stream_end: got %08h want 00000000", s); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  v;
    int          nb;
    int          part;
    for (int f = 0; f < 6; f++) begin
      nb = int'($urandom_range(1, 3));
      part = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      ss_low();
      for (int b = 0; b < nb; b++) begin
        v = 8'($urandom);
        spi_bits(v, 8);
        model_push(v);
      end
      if (part != 0) begin
        spi_bits(8'($urandom), part);
        m_fe = 1'b1;
      end
      ss_high();
    end
    bus_read(STAT, d);
    n_cmp++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL rand_status: got %08h want %08h", d, exp_status()); end
    while (mq.size() > 0) begin
      bus_read(BASE, d);
      e = {24'd0, mq.pop_front()};
      n_cmp++;
      if (d !== e) begin n_fail++; $display("FAIL rand_data: got %08h want %08h", d, e); end
    end
    bus_write(STAT, 32'hC);
    m_fe = 1'b0;
    m_ovr = 1'b0;
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rand_clear: got %08h want 00000000", d); end
  endtask

  task automatic test_reset_midbyte();
    logic [31:0] d;
    logic [31:0] e;
    ss_low();
    spi_bits(8'h11, 8);
    spi_bits(8'h22, 8);
    spi_bits(8'hF0, 4);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_irq: got %b want 1", irq); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq); end
    mq.delete();
    m_fe = 1'b0;
    m_ovr = 1'b0;
    ss = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(STAT, d);
    n_cmp++;
    if (d !== 32'h0 || d !== exp_status()) begin n_fail++; $display("FAIL midrst_status: got %08h want 00000000", d); end
    repeat (4) @(negedge clk);
    ss_low();
    spi_bits(8'h5A, 8);
    model_push(8'h5A);
    ss_high();
    bus_read(BASE, d);
    e = {24'd0, mq.pop_front()};
    n_cmp++;
    if (d !== e) begin n_fail++; $display("FAIL midrst_data: got %08h want %08h", d, e); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_ovr = 1'b0;
    m_fe = 1'b0;
    rst = 1'b1;
    data_address = '0;
    data_rw = 1'b0;
    data_cs = 1'b0;
    sclk = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    tb_drv = 1'b0;
    tb_wdat = '0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_abort();
    test_stream();
    test_random();
    test_reset_midbyte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
